// File: rtl/mcu_pkg.sv
// Shared definitions for the program-memory loader.
//   loader_state_t : loader FSM states
//   PROG_*         : program memory geometry
//   accepts_byte() : states in which the loader takes a stream byte
package mcu_pkg;

  localparam int unsigned PROG_ADDR_W = 11;
  localparam int unsigned PROG_DATA_W = 14;
  localparam int unsigned PROG_DEPTH  = 2048;
  localparam int unsigned COUNT_W     = 12;

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DAT_HI,
    DAT_LO,
    WRITE,
    CHK,
    DONE,
    ERROR
  } loader_state_t;

  function automatic logic accepts_byte(input loader_state_t s);
    return (s == CNT_HI) || (s == CNT_LO) || (s == DAT_HI) ||
           (s == DAT_LO) || (s == CHK);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Program memory loader: parses a host byte frame
//   count_hi, count_lo, count x (data_hi, data_lo), chk
// and writes 14-bit words to program RAM from address 0, holding the CPU in
// reset until a frame with a good 8-bit checksum has been loaded.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   Start              : one-cycle pulse starting a load (IDLE/DONE/ERROR only)
//   Byte_in/valid/ready: byte stream handshake
//   Prog_wr_en/addr/data: program memory write port
//   Cpu_hold           : CPU held in reset
//   Load_done/error    : result of the last load (levels)
module program_loader
  import mcu_pkg::*;
#(
  parameter int unsigned ADDR_W    = PROG_ADDR_W,
  parameter int unsigned DATA_W    = PROG_DATA_W,
  parameter int unsigned MAX_WORDS = PROG_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic [7:0]        Byte_in,
  input  logic              Byte_valid,
  output logic              Byte_ready,
  output logic              Prog_wr_en,
  output logic [ADDR_W-1:0] Prog_addr_out,
  output logic [DATA_W-1:0] Prog_data_out,
  output logic              Cpu_hold,
  output logic              Load_done,
  output logic              Load_error
);

  loader_state_t       state_q, state_d;
  logic [7:0]          sum_q, sum_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [3:0]          cnt_hi_q, cnt_hi_d;
  logic [5:0]          dat_hi_q, dat_hi_d;

  logic                byte_ready_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   addr_out_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                cpu_hold_q;
  logic                done_q;
  logic                error_q;

  logic                accept;
  logic                load_word;
  logic [COUNT_W-1:0]  count;
  logic [7:0]          sum_plus_byte;

  assign accept        = Byte_valid & byte_ready_q;
  assign count         = {cnt_hi_q, Byte_in};
  assign sum_plus_byte = sum_q + Byte_in;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    addr_cnt_d  = addr_cnt_q;
    remaining_d = remaining_q;
    cnt_hi_d    = cnt_hi_q;
    dat_hi_d    = dat_hi_q;
    load_word   = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (Start) begin
          state_d    = CNT_HI;
          sum_d      = 8'h00;
          addr_cnt_d = '0;
        end
      end
      CNT_HI: begin
        if (accept) begin
          sum_d    = sum_plus_byte;
          cnt_hi_d = Byte_in[3:0];
          state_d  = (Byte_in[7:4] != 4'h0) ? ERROR : CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          sum_d       = sum_plus_byte;
          remaining_d = count;
          if (32'(count) > MAX_WORDS) state_d = ERROR;
          else if (count == '0)       state_d = CHK;
          else                        state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (accept) begin
          sum_d    = sum_plus_byte;
          dat_hi_d = Byte_in[5:0];
          state_d  = (Byte_in[7:6] != 2'b00) ? ERROR : DAT_LO;
        end
      end
      DAT_LO: begin
        if (accept) begin
          sum_d     = sum_plus_byte;
          load_word = 1'b1;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        // A full 2048-word load wraps the counter to 0; CHK follows, so no
        // write is ever issued at the wrapped address.
        addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
        remaining_d = remaining_q - COUNT_W'(1);
        state_d     = (remaining_q == COUNT_W'(1)) ? CHK : DAT_HI;
      end
      CHK: begin
        if (accept) state_d = (sum_plus_byte == 8'h00) ? DONE : ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sum_q        <= 8'h00;
      addr_cnt_q   <= '0;
      remaining_q  <= '0;
      cnt_hi_q     <= 4'h0;
      dat_hi_q     <= 6'h00;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_out_q   <= '0;
      data_out_q   <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      addr_cnt_q   <= addr_cnt_d;
      remaining_q  <= remaining_d;
      cnt_hi_q     <= cnt_hi_d;
      dat_hi_q     <= dat_hi_d;
      byte_ready_q <= accepts_byte(state_d);
      wr_en_q      <= (state_d == WRITE);
      cpu_hold_q   <= (state_d != DONE);
      done_q       <= (state_d == DONE);
      error_q      <= (state_d == ERROR);
      if (load_word) begin
        addr_out_q <= addr_cnt_q;
        data_out_q <= DATA_W'({dat_hi_q, Byte_in});
      end
    end
  end

  assign Byte_ready    = byte_ready_q;
  assign Prog_wr_en    = wr_en_q;
  assign Prog_addr_out = addr_out_q;
  assign Prog_data_out = data_out_q;
  assign Cpu_hold      = cpu_hold_q;
  assign Load_done     = done_q;
  assign Load_error    = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Byte_in = 8'h00;
  logic        Byte_valid = 1'b0;
  logic        Byte_ready;
  logic        Prog_wr_en;
  logic [10:0] Prog_addr_out;
  logic [13:0] Prog_data_out;
  logic        Cpu_hold;
  logic        Load_done;
  logic        Load_error;

  int total = 0;
  int bad   = 0;

  logic [10:0] wr_addr_log[$];
  logic [13:0] wr_data_log[$];
  int          ready_in_write = 0;
  logic [7:0]  frame[$];

  program_loader dut (
    .clk          (clk),
    .rst          (rst),
    .Start        (Start),
    .Byte_in      (Byte_in),
    .Byte_valid   (Byte_valid),
    .Byte_ready   (Byte_ready),
    .Prog_wr_en   (Prog_wr_en),
    .Prog_addr_out(Prog_addr_out),
    .Prog_data_out(Prog_data_out),
    .Cpu_hold     (Cpu_hold),
    .Load_done    (Load_done),
    .Load_error   (Load_error)
  );

  always #5 clk = ~clk;

  // Write-port monitor.
  always @(negedge clk) begin
    if (Prog_wr_en) begin
      wr_addr_log.push_back(Prog_addr_out);
      wr_data_log.push_back(Prog_data_out);
      if (Byte_ready) ready_in_write++;
    end
  end

  task automatic clear_log();
    wr_addr_log.delete();
    wr_data_log.delete();
    ready_in_write = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Offer one byte once Byte_ready is seen; bounded wait.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (!Byte_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!Byte_ready) begin
      total++;
      bad++;
      $display("FAIL send_byte_timeout byte=%h ready=%b required=1", b, Byte_ready);
    end else begin
      Byte_in    = b;
      Byte_valid = 1'b1;
      @(posedge clk);
      #1;
      Byte_valid = 1'b0;
    end
  endtask

  // gapped=1 inserts an idle cycle before every other byte.
  task automatic send_frame(input bit gapped);
    for (int k = 0; k < frame.size(); k++)
      send_byte(frame[k], (gapped && (k % 2 == 1)) ? 1 : 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({Byte_ready, Prog_wr_en, Load_done, Load_error} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b required=0000",
               {Byte_ready, Prog_wr_en, Load_done, Load_error});
    end
    total++;
    if (Cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL reset_cpu_hold got=%b required=1", Cpu_hold);
    end
    total++;
    if (Prog_addr_out !== 11'h000 || Prog_data_out !== 14'h0000) begin
      bad++;
      $display("FAIL reset_port got addr=%h data=%h required 000/0000",
               Prog_addr_out, Prog_data_out);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Frame 00 02 | 01 A5 | 30 05 | chk. Byte sum before chk is 0xDD, so 0x23 is good.
  task automatic test_two_word(input string name, input logic [7:0] chk,
                               input bit gapped, input bit expect_ok);
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h02, 8'h01, 8'hA5, 8'h30, 8'h05, chk};
    send_frame(gapped);
    @(negedge clk);
    total++;
    if (wr_addr_log.size() != 2) begin
      bad++;
      $display("FAIL %s_write_count got=%0d required=2", name, wr_addr_log.size());
    end else begin
      total++;
      if (wr_addr_log[0] !== 11'h000 || wr_data_log[0] !== 14'h01A5) begin
        bad++;
        $display("FAIL %s_write0 got addr=%h data=%h required 000/01a5",
                 name, wr_addr_log[0], wr_data_log[0]);
      end
      total++;
      if (wr_addr_log[1] !== 11'h001 || wr_data_log[1] !== 14'h3005) begin
        bad++;
        $display("FAIL %s_write1 got addr=%h data=%h required 001/3005",
                 name, wr_addr_log[1], wr_data_log[1]);
      end
    end
    total++;
    if (ready_in_write != 0) begin
      bad++;
      $display("FAIL %s_ready_in_write got=%0d required=0", name, ready_in_write);
    end
    total++;
    if (Prog_addr_out !== 11'h001) begin
      bad++;
      $display("FAIL %s_addr_hold got=%h required=001", name, Prog_addr_out);
    end
    total++;
    if ({Load_done, Load_error, Cpu_hold} !== (expect_ok ? 3'b100 : 3'b011)) begin
      bad++;
      $display("FAIL %s_status got done/err/hold=%b required=%b", name,
               {Load_done, Load_error, Cpu_hold}, expect_ok ? 3'b100 : 3'b011);
    end
  endtask

  task automatic test_zero_count();
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (wr_addr_log.size() != 0 || Load_done !== 1'b1 || Cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL zero_count got writes=%0d done=%b hold=%b required 0/1/0",
               wr_addr_log.size(), Load_done, Cpu_hold);
    end
  endtask

  task automatic test_format_errors();
    // count 0x801 = 2049 > 2048
    clear_log();
    pulse_start();
    frame = '{8'h08, 8'h01};
    send_frame(1'b0);
    @(negedge clk);
    total++;
    if ({Load_error, Load_done, Cpu_hold, Byte_ready} !== 4'b1010) begin
      bad++;
      $display("FAIL count_overflow got err/done/hold/ready=%b required=1010",
               {Load_error, Load_done, Cpu_hold, Byte_ready});
    end
    // count_hi upper nibble nonzero
    pulse_start();
    frame = '{8'h10};
    send_frame(1'b0);
    @(negedge clk);
    total++;
    if (Load_error !== 1'b1 || Byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL count_hi_nibble got err=%b ready=%b required 1/0",
               Load_error, Byte_ready);
    end
    // data_hi with bit 6 set
    pulse_start();
    frame = '{8'h00, 8'h01, 8'h40};
    send_frame(1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (Load_error !== 1'b1 || Cpu_hold !== 1'b1) begin
      bad++;
      $display("FAIL data_hi_error got err=%b hold=%b required 1/1", Load_error, Cpu_hold);
    end
    total++;
    if (wr_addr_log.size() != 0) begin
      bad++;
      $display("FAIL format_error_writes got=%0d required=0", wr_addr_log.size());
    end
  endtask

  // Start in CNT_LO must be ignored; frame 00 00 00 then completes.
  task automatic test_start_ignored();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    total++;
    if (Load_done !== 1'b1 || Load_error !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored got done=%b err=%b required 1/0", Load_done, Load_error);
    end
  endtask

  task automatic test_midload_reset();
    clear_log();
    pulse_start();
    frame = '{8'h00, 8'h05, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
    send_frame(1'b0);
    // Now in DAT_LO of the fourth word; offer data_lo while resetting.
    @(negedge clk);
    rst        = 1'b1;
    Byte_in    = 8'h04;
    Byte_valid = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    Byte_valid = 1'b0;
    total++;
    if ({Cpu_hold, Prog_wr_en, Byte_ready, Load_done, Load_error} !== 5'b10000) begin
      bad++;
      $display("FAIL midreset_flags got hold/wr/ready/done/err=%b required=10000",
               {Cpu_hold, Prog_wr_en, Byte_ready, Load_done, Load_error});
    end
    total++;
    if (Prog_addr_out !== 11'h000) begin
      bad++;
      $display("FAIL midreset_addr got=%h required=000", Prog_addr_out);
    end
    repeat (3) @(negedge clk);
    total++;
    if (wr_addr_log.size() != 3 || Byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL midreset_writes got writes=%0d ready=%b required 3/0",
               wr_addr_log.size(), Byte_ready);
    end
  endtask

  // count = 2048: word i is {i[13:8], i[7:0]} at address i.
  task automatic test_full_depth();
    logic [7:0]  sum;
    logic [13:0] w;
    int          errs;
    clear_log();
    pulse_start();
    frame = {};
    frame.push_back(8'h08);
    frame.push_back(8'h00);
    sum = 8'h08;
    for (int i = 0; i < 2048; i++) begin
      w = 14'(i);
      frame.push_back({2'b00, w[13:8]});
      frame.push_back(w[7:0]);
      sum = sum + {2'b00, w[13:8]} + w[7:0];
    end
    frame.push_back(8'h00 - sum);
    send_frame(1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (wr_addr_log.size() != 2048) begin
      bad++;
      $display("FAIL full_write_count got=%0d required=2048", wr_addr_log.size());
    end else begin
      errs = 0;
      for (int i = 0; i < 2048; i++)
        if (wr_addr_log[i] !== 11'(i) || wr_data_log[i] !== 14'(i)) errs++;
      total++;
      if (errs != 0) begin
        bad++;
        $display("FAIL full_write_contents got=%0d wrong words required=0", errs);
      end
    end
    total++;
    if (Prog_addr_out !== 11'h7FF || Load_done !== 1'b1 || Cpu_hold !== 1'b0) begin
      bad++;
      $display("FAIL full_final got addr=%h done=%b hold=%b required 7ff/1/0",
               Prog_addr_out, Load_done, Cpu_hold);
    end
  endtask

  initial begin
    test_reset();
    test_two_word("good", 8'h23, 1'b0, 1'b1);
    test_two_word("badchk", 8'h24, 1'b0, 1'b0);
    test_zero_count();
    test_format_errors();
    test_two_word("gapped", 8'h23, 1'b1, 1'b1);
    test_start_ignored();
    test_midload_reset();
    test_two_word("after_reset", 8'h23, 1'b0, 1'b1);
    test_full_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
